// File: rtl/bus_interface_unit.sv
// Bus interface unit: owns the program counter and runs one multiplexed external bus cycle
// (address low, address high, data) per CPU step. It pulses clk_enable once per completed step.
// Pin outputs are registered, so each phase's pin values appear in the cycle after that phase.
// The last data-phase pin cycle therefore coincides with the commit phase, and read data is
// sampled at the edge that ends the commit phase.
module bus_interface_unit #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter int unsigned WAIT_CYCLES  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  pc_enable,
    input  logic [1:0]  address_select,
    input  logic [15:0] memory_address,
    input  logic [7:0]  alu_result,
    input  logic        rw,
    input  logic [7:0]  data_out,
    output logic [7:0]  instruction,
    output logic        clk_enable,
    output logic [15:0] pc,
    output logic [7:0]  bus_out,
    output logic [7:0]  bus_oe,
    input  logic [7:0]  bus_in,
    output logic        ale_lo,
    output logic        ale_hi,
    output logic        we_n
);

    localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {PAdl, PAdh, PData, PCommit} phase_t;

    phase_t      phase;
    logic [3:0]  wait_cnt;
    logic [15:0] addr_q;
    logic        rw_q;
    logic [7:0]  wdata_q;
    logic [15:0] sel_addr;

    // Address source for the step about to start; selector 3 is reserved and aliases PC.
    always_comb begin
        sel_addr = pc;
        case (address_select)
            2'd1:    sel_addr = memory_address;
            2'd2:    sel_addr = {8'h00, alu_result};
            default: sel_addr = pc;
        endcase
    end

    // Step sequencer with registered pin, strobe, instruction and PC outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase       <= PAdl;
            wait_cnt    <= 4'd0;
            addr_q      <= 16'h0000;
            rw_q        <= 1'b1;
            wdata_q     <= 8'h00;
            pc          <= RESET_VECTOR;
            instruction <= 8'h00;
            clk_enable  <= 1'b0;
            bus_out     <= 8'h00;
            bus_oe      <= 8'h00;
            ale_lo      <= 1'b0;
            ale_hi      <= 1'b0;
            we_n        <= 1'b1;
        end else begin
            clk_enable <= 1'b0;
            case (phase)
                PAdl: begin
                    // Decoder inputs are only trusted here; the rest of the step uses copies.
                    addr_q  <= sel_addr;
                    rw_q    <= rw;
                    wdata_q <= data_out;
                    bus_out <= sel_addr[7:0];
                    bus_oe  <= 8'hFF;
                    ale_lo  <= 1'b1;
                    phase   <= PAdh;
                end
                PAdh: begin
                    ale_lo   <= 1'b0;
                    ale_hi   <= 1'b1;
                    bus_out  <= addr_q[15:8];
                    bus_oe   <= 8'hFF;
                    wait_cnt <= WaitInit;
                    phase    <= PData;
                end
                PData: begin
                    ale_hi <= 1'b0;
                    if (rw_q) begin
                        bus_oe  <= 8'h00;
                        bus_out <= 8'h00;
                        we_n    <= 1'b1;
                    end else begin
                        bus_oe  <= 8'hFF;
                        bus_out <= wdata_q;
                        we_n    <= 1'b0;
                    end
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        phase <= PCommit;
                    end
                end
                PCommit: begin
                    // Pins go quiet for one cycle so a read never collides with the next ADL.
                    clk_enable <= 1'b1;
                    bus_oe     <= 8'h00;
                    bus_out    <= 8'h00;
                    we_n       <= 1'b1;
                    if (rw_q) begin
                        instruction <= bus_in;
                    end
                    if (pc_enable == 2'b11) begin
                        pc <= pc + 16'd1;
                    end
                    phase <= PAdl;
                end
                default: phase <= PAdl;
            endcase
        end
    end

endmodule
